// File: rtl/zeroriscy_dma_pkg.sv
// Shared types and constants for the zeroriscy DMA copier and its memory request port.
package zeroriscy_dma_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } dma_state_e;

  localparam logic [3:0]  BE_FULL         = 4'hF;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ADDR_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/zeroriscy_mem_req_port.sv
// Single-outstanding initiator port: holds req/we/addr/wdata until gnt, then
// waits for the one matching rvalid.
module zeroriscy_mem_req_port
  import zeroriscy_dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        start_we,
  input  logic [31:0] start_addr,
  input  logic [31:0] start_wdata,
  input  logic        data_gnt,
  input  logic        data_rvalid,
  input  logic        data_err,
  input  logic [31:0] data_rdata,
  output logic        data_req,
  output logic        data_we,
  output logic [3:0]  data_be,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata
);

  logic        req_r;
  logic        we_r;
  logic        pend_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;

  // Request fields are loaded on start and frozen until the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_r   <= 1'b0;
      we_r    <= 1'b0;
      pend_r  <= 1'b0;
      addr_r  <= 32'h0;
      wdata_r <= 32'h0;
    end else begin
      if (start) begin
        req_r   <= 1'b1;
        we_r    <= start_we;
        addr_r  <= align_word(start_addr);
        wdata_r <= start_wdata;
      end else if (req_r && data_gnt) begin
        req_r <= 1'b0;
      end
      if (req_r && data_gnt) begin
        pend_r <= 1'b1;
      end else if (pend_r && data_rvalid) begin
        pend_r <= 1'b0;
      end
    end
  end

  assign data_req   = req_r;
  assign data_we    = we_r;
  assign data_be    = BE_FULL;
  assign data_addr  = addr_r;
  assign data_wdata = wdata_r;

  // Stray rvalids (none outstanding, e.g. straight after reset) are dropped here.
  assign resp_valid = pend_r & data_rvalid;
  assign resp_err   = pend_r & data_rvalid & data_err;
  assign resp_rdata = data_rdata;

endmodule

// File: rtl/zeroriscy_dma_copier.sv
// Word-by-word memory copier on the zeroriscy data port (read, then write).
// Optional ZERORISCY_DMA_FILL_EN adds a pattern-fill mode (cmd_fill/cmd_pattern).
module zeroriscy_dma_copier
  import zeroriscy_dma_pkg::*;
#(
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned ADDR_INC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_src,
  input  logic [31:0]      cmd_dst,
  input  logic [LEN_W-1:0] cmd_len,
`ifdef ZERORISCY_DMA_FILL_EN
  input  logic             cmd_fill,
  input  logic [31:0]      cmd_pattern,
`endif
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             data_req,
  output logic             data_we,
  output logic [3:0]       data_be,
  output logic [31:0]      data_addr,
  output logic [31:0]      data_wdata,
  input  logic [31:0]      data_rdata,
  input  logic             data_gnt,
  input  logic             data_rvalid,
  input  logic             data_err
);

  localparam logic [LEN_W-1:0] LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]      ADDR_STEP = 32'(ADDR_INC);

  dma_state_e       state_r, state_d;
  logic [31:0]      src_r, src_d, dst_r, dst_d, wdata_r, wdata_d;
  logic [LEN_W-1:0] rem_r, rem_d;
  logic             fill_r, fill_d, err_r, err_d;
  logic             busy_r, busy_d, done_r, done_d, ready_r, ready_d;
  logic             accept_s, rd_start_s, wr_start_s;
  logic             resp_valid_s, resp_err_s, resp_ok_s;
  logic [31:0]      resp_rdata_s;
  logic             cmd_fill_s;
  logic [31:0]      cmd_pattern_s;

`ifdef ZERORISCY_DMA_FILL_EN
  assign cmd_fill_s    = cmd_fill;
  assign cmd_pattern_s = cmd_pattern;
`else
  assign cmd_fill_s    = 1'b0;
  assign cmd_pattern_s = 32'h0;
`endif

  assign accept_s  = cmd_valid && (state_r == IDLE);
  assign resp_ok_s = resp_valid_s && !resp_err_s;

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      src_r   <= 32'h0;
      dst_r   <= 32'h0;
      wdata_r <= 32'h0;
      rem_r   <= LEN_ZERO;
      fill_r  <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_d;
      src_r   <= src_d;
      dst_r   <= dst_d;
      wdata_r <= wdata_d;
      rem_r   <= rem_d;
      fill_r  <= fill_d;
      err_r   <= err_d;
      busy_r  <= busy_d;
      done_r  <= done_d;
      ready_r <= ready_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s)                state_d = IDLE;
        else if (cmd_len == LEN_ZERO) state_d = DONE;
        else if (cmd_fill_s)          state_d = WR_REQ;
        else                          state_d = RD_REQ;
      end
      RD_REQ: begin
        if (data_gnt) state_d = RD_WAIT;
        else          state_d = RD_REQ;
      end
      RD_WAIT: begin
        if (resp_err_s)     state_d = DONE;
        else if (resp_ok_s) state_d = WR_REQ;
        else                state_d = RD_WAIT;
      end
      WR_REQ: begin
        if (data_gnt) state_d = WR_WAIT;
        else          state_d = WR_REQ;
      end
      WR_WAIT: begin
        if (resp_err_s)              state_d = DONE;
        else if (!resp_ok_s)         state_d = WR_WAIT;
        else if (rem_r == LEN_ONE)   state_d = DONE;
        else if (fill_r)             state_d = WR_REQ;
        else                         state_d = RD_REQ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates, request launches and next status outputs.
  always_comb begin
    src_d   = src_r;
    dst_d   = dst_r;
    wdata_d = wdata_r;
    rem_d   = rem_r;
    fill_d  = fill_r;
    err_d   = err_r;
    if (accept_s) begin
      src_d   = align_word(cmd_src);
      dst_d   = align_word(cmd_dst);
      rem_d   = cmd_len;
      fill_d  = cmd_fill_s;
      err_d   = 1'b0;
      wdata_d = cmd_fill_s ? cmd_pattern_s : wdata_r;
    end else if (resp_err_s && (state_r == RD_WAIT || state_r == WR_WAIT)) begin
      err_d = 1'b1;
    end else if (resp_ok_s && state_r == RD_WAIT) begin
      wdata_d = resp_rdata_s;
    end else if (resp_ok_s && state_r == WR_WAIT) begin
      src_d = src_r + ADDR_STEP;
      dst_d = dst_r + ADDR_STEP;
      rem_d = rem_r - LEN_ONE;
    end else begin
      err_d = err_r;
    end
    rd_start_s = (state_d == RD_REQ) && (state_r != RD_REQ);
    wr_start_s = (state_d == WR_REQ) && (state_r != WR_REQ);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    ready_d    = (state_d == IDLE);
  end

  zeroriscy_mem_req_port u_port (
    .clk         (clk),
    .rst         (rst),
    .start       (rd_start_s | wr_start_s),
    .start_we    (wr_start_s),
    .start_addr  (wr_start_s ? dst_d : src_d),
    .start_wdata (wdata_d),
    .data_gnt    (data_gnt),
    .data_rvalid (data_rvalid),
    .data_err    (data_err),
    .data_rdata  (data_rdata),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_be     (data_be),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .resp_valid  (resp_valid_s),
    .resp_err    (resp_err_s),
    .resp_rdata  (resp_rdata_s)
  );

  assign cmd_ready = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule
